// File: rtl/data_route_pkg.sv
// ----------------------------------------------------------------------------
// data_route_pkg
// Shared definitions for the 256-bit to 1536-bit beat packer.
//   DW_IN      : width of one narrow input beat
//   DW_OUT     : width of one packed output word
//   BEATS_MAX  : number of 256-bit lanes in an output word
//   route_state_e : FILL (accumulating, input ready) / HOLD (word parked)
//   effBeats() : maps the raw beat_num input to the beats-per-word value
// ----------------------------------------------------------------------------
package data_route_pkg;

   localparam int DW_IN     = 256;
   localparam int DW_OUT    = 1536;
   localparam int BEATS_MAX = 6;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } route_state_e;

   // Values 0 and 7 have no meaning as a lane count, so they fall back to a
   // full word rather than producing an empty or oversized one.
   function automatic logic [2:0] effBeats(input logic [2:0] rawBeats);
      if ((rawBeats == 3'd0) || (rawBeats == 3'd7)) begin
         return 3'(BEATS_MAX);
      end
      return rawBeats;
   endfunction

endpackage

// File: rtl/in256_out1536_flex.sv
// ----------------------------------------------------------------------------
// in256_out1536_flex
// Packs 1..6 narrow 256-bit AXI-Stream beats into one 1536-bit word.
// An accumulator collects lanes while a separate output register presents the
// previous word, so a full-rate stream passes with no bubbles.
// Ports:
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   beat_num          : beats per word (0/7 mean 6), latched on a word's beat 0
//   s_axis_tdata/tvalid/tready/tlast : narrow input, tlast closes a word early
//   m_axis_tdata/tvalid/tready       : packed output word
//   m_axis_beats      : number of valid lanes in the presented word
// ----------------------------------------------------------------------------
module in256_out1536_flex
   import data_route_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2:0]          beat_num,
   input  logic [DW_IN-1:0]    s_axis_tdata,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   input  logic                s_axis_tlast,
   output logic [DW_OUT-1:0]   m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic [2:0]          m_axis_beats
);

   route_state_e        state_q, state_d;
   logic                alive_q;
   logic [2:0]          cnt_q, cnt_d;
   logic [2:0]          beats_q, beats_d;
   logic [DW_OUT-1:0]   acc_q, acc_d;
   logic [DW_OUT-1:0]   out_q, out_d;
   logic                outValid_q, outValid_d;
   logic [2:0]          outBeats_q, outBeats_d;

   logic                accept;
   logic                drain;
   logic                outFree;
   logic                closing;
   logic [2:0]          wordBeats;
   logic [DW_OUT-1:0]   merged;

   // Input readiness comes from a flop that only rises after the first clock
   // edge out of reset, so the input stays stalled throughout reset even
   // though the state register already sits in FILL.
   assign s_axis_tready = alive_q && (state_q == FILL);
   assign m_axis_tdata  = out_q;
   assign m_axis_tvalid = outValid_q;
   assign m_axis_beats  = outBeats_q;

   // Handshake decode plus the accumulator image with the incoming beat
   // dropped into its lane. beats_q holds the word length latched on beat 0;
   // on beat 0 itself the live beat_num is used instead. The close decision
   // looks at either the length limit or an early tlast.
   always_comb begin
      accept    = s_axis_tvalid && s_axis_tready;
      drain     = outValid_q && m_axis_tready;
      outFree   = !outValid_q || m_axis_tready;
      wordBeats = (cnt_q == 3'd0) ? effBeats(beat_num) : beats_q;
      closing   = accept && (s_axis_tlast || (cnt_q == (wordBeats - 3'd1)));
      merged    = acc_q;
      for (int i = 0; i < BEATS_MAX; i++) begin
         if (cnt_q == 3'(i)) begin
            merged[i*DW_IN +: DW_IN] = s_axis_tdata;
         end
      end
   end

   // Next-state logic. In FILL a closing beat goes straight to the output
   // register when it is free (or being drained this cycle); otherwise the
   // finished word is parked in the accumulator and input is stalled in HOLD.
   // beats_q doubles as the parked word's lane count while in HOLD. The
   // accumulator is zeroed whenever a word leaves it, which is what keeps
   // unused upper lanes at zero in short words.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      beats_d    = beats_q;
      acc_d      = acc_q;
      out_d      = out_q;
      outValid_d = outValid_q;
      outBeats_d = outBeats_q;

      if (drain) begin
         outValid_d = 1'b0;
      end

      unique case (state_q)
         FILL: begin
            if (accept) begin
               if (closing) begin
                  cnt_d = 3'd0;
                  if (outFree) begin
                     out_d      = merged;
                     outBeats_d = cnt_q + 3'd1;
                     outValid_d = 1'b1;
                     acc_d      = '0;
                  end else begin
                     acc_d   = merged;
                     beats_d = cnt_q + 3'd1;
                     state_d = HOLD;
                  end
               end else begin
                  acc_d   = merged;
                  cnt_d   = cnt_q + 3'd1;
                  beats_d = wordBeats;
               end
            end
         end
         HOLD: begin
            if (drain) begin
               out_d      = acc_q;
               outBeats_d = beats_q;
               outValid_d = 1'b1;
               acc_d      = '0;
               state_d    = FILL;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // State and datapath registers. Reset discards any partial or parked word
   // and clears the presented word so that nothing stale survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FILL;
         alive_q    <= 1'b0;
         cnt_q      <= 3'd0;
         beats_q    <= 3'd0;
         acc_q      <= '0;
         out_q      <= '0;
         outValid_q <= 1'b0;
         outBeats_q <= 3'd0;
      end else begin
         state_q    <= state_d;
         alive_q    <= 1'b1;
         cnt_q      <= cnt_d;
         beats_q    <= beats_d;
         acc_q      <= acc_d;
         out_q      <= out_d;
         outValid_q <= outValid_d;
         outBeats_q <= outBeats_d;
      end
   end

endmodule

// File: tb/tb_in256_out1536_flex.sv
// ----------------------------------------------------------------------------
// tb_in256_out1536_flex
// Self-checking bench for the 256->1536 beat packer. A reference model
// follows every input handshake and queues the expected packed words; a
// monitor pops and compares each word as it is handed off on m_axis.
// ----------------------------------------------------------------------------
module tb_in256_out1536_flex;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    beat_num = 3'd6;
   logic [255:0]  s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tlast = 1'b0;
   logic [1535:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic [2:0]    m_beats;

   typedef struct packed {
      logic [1535:0] data;
      logic [2:0]    beats;
   } word_t;

   word_t         expQ[$];
   int            testsRun = 0;
   int            testsFailed = 0;
   int            wordsSeen = 0;
   logic [1535:0] modelAcc = '0;
   logic [2:0]    modelCnt = 3'd0;
   logic [2:0]    modelN = 3'd6;
   bit            waited = 1'b0;
   bit            randDone = 1'b0;

   always #5 clk = ~clk;

   in256_out1536_flex dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .beat_num      (beat_num),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_beats  (m_beats)
   );

   // Samples both interfaces on the falling edge: an output handshake pops
   // and compares against the scoreboard, an input handshake feeds the model.
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            expQ.delete();
            modelCnt = 3'd0;
            modelAcc = '0;
         end else begin
            if (m_tvalid && m_tready) begin
               testsRun++;
               if (expQ.size() == 0) begin
                  testsFailed++;
                  $display("[TB] FAIL unexpected_word got beats=%0d with empty scoreboard", m_beats);
               end else begin
                  word_t e;
                  int bad;
                  e = expQ.pop_front();
                  bad = -1;
                  for (int l = 0; l < 6; l++) begin
                     if ((m_tdata[l*256 +: 256] !== e.data[l*256 +: 256]) && (bad < 0)) bad = l;
                  end
                  if ((bad >= 0) || (m_beats !== e.beats)) begin
                     testsFailed++;
                     if (bad < 0) bad = 0;
                     $display("[TB] FAIL word_%0d beats got %0d want %0d lane%0d got %h want %h",
                              wordsSeen, m_beats, e.beats, bad,
                              m_tdata[bad*256 +: 256], e.data[bad*256 +: 256]);
                  end
                  wordsSeen++;
               end
            end
            if (s_tvalid && s_tready) begin
               if (modelCnt == 3'd0) begin
                  modelN = ((beat_num == 3'd0) || (beat_num == 3'd7)) ? 3'd6 : beat_num;
               end
               modelAcc[modelCnt*256 +: 256] = s_tdata;
               if (s_tlast || ((modelCnt + 3'd1) == modelN)) begin
                  expQ.push_back('{data: modelAcc, beats: modelCnt + 3'd1});
                  modelAcc = '0;
                  modelCnt = 3'd0;
               end else begin
                  modelCnt = modelCnt + 3'd1;
               end
            end
         end
      end
   endtask

   // Offers one beat and holds it until accepted (bounded); returns one
   // tick after the accepting edge so back-to-back calls have no bubble.
   task automatic applyStimulus(input logic [255:0] d, input logic last);
      int guard;
      s_tdata  = d;
      s_tlast  = last;
      s_tvalid = 1'b1;
      guard    = 0;
      @(negedge clk);
      while (!s_tready && (guard < 300)) begin
         waited = 1'b1;
         guard++;
         @(negedge clk);
      end
      if (!s_tready) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL beat_accept_timeout data=%h s_axis_tready=%b", d[15:0], s_tready);
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   // Waits (bounded) until every expected word has been handed off.
   task automatic checkOutput(input string name);
      int guard;
      guard = 0;
      while (((expQ.size() != 0) || m_tvalid) && (guard < 400)) begin
         guard++;
         @(negedge clk);
      end
      testsRun++;
      if ((expQ.size() != 0) || m_tvalid) begin
         testsFailed++;
         $display("[TB] FAIL %s_drain pending=%0d m_axis_tvalid=%b want 0 and 0", name, expQ.size(), m_tvalid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      testsRun++;
      if ((s_tready !== 1'b0) || (m_tvalid !== 1'b0) || (m_beats !== 3'd0) || (m_tdata !== '0)) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs tready=%b tvalid=%b beats=%0d lane0=%h want all 0",
                  s_tready, m_tvalid, m_beats, m_tdata[255:0]);
      end
      rst_n = 1'b1;
      @(negedge clk);
      testsRun++;
      if (s_tready !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_ready_early got %b want 0", s_tready);
      end
      @(posedge clk);
      #1;
      testsRun++;
      if (s_tready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL reset_ready_rise got %b want 1", s_tready);
      end
   endtask

   task automatic test_full_word();
      int w0;
      w0 = wordsSeen;
      beat_num = 3'd6;
      m_tready = 1'b1;
      for (int k = 1; k <= 5; k++) applyStimulus(256'(k), 1'b0);
      testsRun++;
      if (m_tvalid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL full_early_valid got %b want 0", m_tvalid);
      end
      applyStimulus(256'(6), 1'b0);
      testsRun++;
      if ((m_tvalid !== 1'b1) || (m_beats !== 3'd6)) begin
         testsFailed++;
         $display("[TB] FAIL full_latency tvalid=%b beats=%0d want 1 and 6", m_tvalid, m_beats);
      end
      checkOutput("full");
      testsRun++;
      if (wordsSeen - w0 != 1) begin
         testsFailed++;
         $display("[TB] FAIL full_count got %0d want 1", wordsSeen - w0);
      end
   endtask

   task automatic test_three_beat();
      int w0;
      w0 = wordsSeen;
      beat_num = 3'd3;
      waited = 1'b0;
      for (int k = 0; k < 9; k++) applyStimulus(256'(8'h40 + k), 1'b0);
      checkOutput("three");
      testsRun++;
      if ((wordsSeen - w0 != 3) || waited) begin
         testsFailed++;
         $display("[TB] FAIL three_count words=%0d stalled=%b want 3 and 0", wordsSeen - w0, waited);
      end
   endtask

   task automatic test_tlast();
      beat_num = 3'd6;
      applyStimulus(256'(8'h77), 1'b1);
      testsRun++;
      if ((m_tvalid !== 1'b1) || (m_beats !== 3'd1)) begin
         testsFailed++;
         $display("[TB] FAIL tlast_single tvalid=%b beats=%0d want 1 and 1", m_tvalid, m_beats);
      end
      applyStimulus(256'(8'h21), 1'b0);
      applyStimulus(256'(8'h22), 1'b1);
      testsRun++;
      if ((m_tvalid !== 1'b1) || (m_beats !== 3'd2)) begin
         testsFailed++;
         $display("[TB] FAIL tlast_two tvalid=%b beats=%0d want 1 and 2", m_tvalid, m_beats);
      end
      for (int k = 0; k < 6; k++) applyStimulus(256'(8'h31 + k), 1'b0);
      checkOutput("tlast");
   endtask

   task automatic test_back_to_back();
      logic [1535:0] snap;
      beat_num = 3'd6;
      m_tready = 1'b0;
      for (int k = 0; k < 12; k++) applyStimulus({248'h0, 8'h80 + 8'(k)}, 1'b0);
      testsRun++;
      if ((s_tready !== 1'b0) || (m_tvalid !== 1'b1)) begin
         testsFailed++;
         $display("[TB] FAIL stall_enter tready=%b tvalid=%b want 0 and 1", s_tready, m_tvalid);
      end
      snap = m_tdata;
      repeat (3) @(negedge clk);
      testsRun++;
      if ((m_tdata !== snap) || (m_tvalid !== 1'b1) || (m_beats !== 3'd6)) begin
         testsFailed++;
         $display("[TB] FAIL stall_stable tvalid=%b beats=%0d lane0=%h want 1, 6, %h",
                  m_tvalid, m_beats, m_tdata[255:0], snap[255:0]);
      end
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      @(negedge clk);
      testsRun++;
      if (s_tready !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL stall_ready_before got %b want 0", s_tready);
      end
      @(posedge clk);
      #1;
      testsRun++;
      if (s_tready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL stall_ready_rise got %b want 1", s_tready);
      end
      checkOutput("stall");
   endtask

   task automatic test_beat_num_change();
      int w0;
      w0 = wordsSeen;
      beat_num = 3'd6;
      for (int k = 0; k < 3; k++) applyStimulus(256'(8'hC0 + k), 1'b0);
      beat_num = 3'd2;
      for (int k = 3; k < 6; k++) applyStimulus(256'(8'hC0 + k), 1'b0);
      for (int k = 6; k < 8; k++) applyStimulus(256'(8'hC0 + k), 1'b0);
      checkOutput("bnum");
      testsRun++;
      if (wordsSeen - w0 != 2) begin
         testsFailed++;
         $display("[TB] FAIL bnum_count got %0d want 2", wordsSeen - w0);
      end
   endtask

   task automatic test_mid_reset();
      beat_num = 3'd6;
      for (int k = 0; k < 4; k++) applyStimulus(256'(8'hE0 + k), 1'b0);
      rst_n = 1'b0;
      #1;
      testsRun++;
      if ((s_tready !== 1'b0) || (m_tvalid !== 1'b0) || (m_beats !== 3'd0) || (m_tdata !== '0)) begin
         testsFailed++;
         $display("[TB] FAIL midreset_outputs tready=%b tvalid=%b beats=%0d want 0 0 0", s_tready, m_tvalid, m_beats);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 6; k++) applyStimulus(256'(8'h11 + k), 1'b0);
      checkOutput("midreset");
   endtask

   task automatic test_random();
      int w0;
      w0 = wordsSeen;
      randDone = 1'b0;
      fork
         begin
            while (!randDone) begin
               @(posedge clk);
               #1;
               m_tready = 1'($urandom_range(0, 1));
            end
            m_tready = 1'b1;
         end
         begin
            for (int k = 0; k < 80; k++) begin
               beat_num = 3'($urandom_range(0, 7));
               applyStimulus({$urandom, $urandom, 192'h0, 32'(k)}, ($urandom_range(0, 4) == 0));
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
            end
            randDone = 1'b1;
         end
      join
      checkOutput("random");
      testsRun++;
      if (wordsSeen - w0 < 13) begin
         testsFailed++;
         $display("[TB] FAIL random_count got %0d want at least 13", wordsSeen - w0);
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_full_word();
      test_three_beat();
      test_tlast();
      test_back_to_back();
      test_beat_num_change();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
